core_bpu_arbiter: RTL
=====================

Name: core_bpu_arbiter

Overview:
- Collects branch-resolution results from the two issue slots' jump units and decides which one redirects the front end.
- Suppresses wrong-path results for a fixed squash window after each redirect.
- Buffers BPU training updates in a small 2-in/1-out FIFO and drains them to the BPU over a valid/ready handshake.
- Sits between the execute-stage jump units and the front-end/BPU correction port.

Parameters:
- DEPTH, 8, update FIFO entries; power of two, ≥4.
- SQUASH_CYC, 3, cycles after a redirect during which slot inputs are ignored; ≥1.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- valid_i  in  2  per-slot branch-result valid; slot 0 is older
- correct_i  in  2 x bpu_correct_t  per-slot result from the jump units
- redirect_o  out  1  one-cycle front-end flush/redirect pulse
- redirect_pc_o  out  32  redirect target = winning entry's true_target
- redirect_ras_ptr_o  out  RAS ptr width  RAS pointer restore value = winning entry's ras_ptr
- upd_valid_o  out  1  FIFO head valid
- upd_ready_i  in  1  BPU accepts the head entry
- upd_o  out  bpu_correct_t  FIFO head entry
- stall_o  out  1  back-pressure to issue; high when free entries < 2

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO emptied, state IDLE, squash counter = 0.
  - redirect_o=0, upd_valid_o=0, stall_o=0; redirect_pc_o and redirect_ras_ptr_o = 0.
  - Reset mid-drain discards all queued entries; no partial handshake survives.
- States:
  - IDLE: inputs are processed.
  - SQUASH: inputs are ignored. The counter loads SQUASH_CYC-1 on entry and decrements each cycle. On the cycle it reads 0, the state returns to IDLE; inputs are processed again from the next cycle.
- Slot qualification, IDLE only:
  - s0 = valid_i[0].
  - kill1 = s0 & correct_i[0].miss.
  - s1 = valid_i[1] & ~kill1.
  - Slot 1 is younger; once killed, it is neither enqueued nor allowed to redirect.
- Redirect:
  - Winner = slot 0 if s0 & miss0, else slot 1 if s1 & miss1.
  - redirect_o, redirect_pc_o and redirect_ras_ptr_o are registered, valid exactly one cycle after the input cycle.
  - The state enters SQUASH in that same cycle.
  - redirect_pc_o and redirect_ras_ptr_o hold their values until the next redirect.
- Enqueue:
  - A qualified slot is enqueued if need_update | miss.
  - 0, 1 or 2 entries per cycle; slot 0 is written first (older at the lower position).
- Dequeue: the head is popped when upd_valid_o & upd_ready_i.
- upd_o is the registered head entry, stable while upd_valid_o=1 and upd_ready_i=0.
- Simultaneous push and pop are legal. Count update = count + pushes − pop; wr/rd pointers wrap mod DEPTH.
- Empty: upd_valid_o=0, upd_o don't-care.
- stall_o:
  - Combinational from the registered count: stall_o = (DEPTH − count) < 2.
  - Issue guarantees valid_i=0 while stall_o=1.
  - A push beyond full is illegal and is flagged by a bench assertion.
- In SQUASH, FIFO draining continues normally.

Decomposition:
- Shared package (pipeline.svh): bpu_correct_t (existing) and a new arb_state_e enum {ARB_IDLE, ARB_SQUASH}.
- Sub-module core_bpu_upd_fifo:
  - Parameters: DEPTH.
  - Ports: 2 push valids + data, 1 pop, head data/valid, count.
- The top-level module holds qualification, redirect registers and squash FSM.

Test Plan:
1. Reset then idle → redirect_o=0, upd_valid_o=0, stall_o=0 for 10 cycles.
2. Slot0 miss (true_target=0x1C00_0040, ras_ptr=3) plus slot1 valid with need_update → redirect_o=1 next cycle with pc 0x1C00_0040 and ras_ptr 3; only the slot0 entry is enqueued; valid inputs on the next SQUASH_CYC=3 cycles are ignored (count unchanged); an input on the 4th cycle is accepted.
3. Slot0 valid without miss, slot1 miss (true_target=0x1C00_0100) → redirect_pc_o=0x1C00_0100; both entries enqueued, slot0 at the head.
4. upd_ready_i=0, push pairs until count=7 with DEPTH=8 → stall_o=1 at count 7; raising ready pops one per cycle in FIFO order; stall_o falls at count 6.
5. Push 1 and pop 1 in the same cycle at count=3 → count stays 3; pointer wraps correctly over 20 cycles of mixed traffic.
6. Assert rst during SQUASH with 5 entries queued → next cycle state IDLE, upd_valid_o=0, count=0; a miss on the following cycle redirects normally.

Source files
------------

// File: rtl/core_bpu_arbiter_pkg.sv
// Shared types for the branch-resolution arbiter: jump-unit result record
// and the arbiter's squash FSM states.
package core_bpu_arbiter_pkg;

    localparam int RAS_PTR_W = 4;

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          true_target;
        logic [RAS_PTR_W-1:0] ras_ptr;
        logic                 taken;
        logic                 miss;
        logic                 need_update;
    } bpu_correct_t;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_SQUASH = 1'b1
    } arb_state_e;

    // An entry trains the BPU when it either mispredicted or asked for an update.
    function automatic logic entry_wanted(input bpu_correct_t e);
        return e.need_update | e.miss;
    endfunction

endpackage

// File: rtl/core_bpu_upd_fifo.sv
// Two-write/one-read FIFO for BPU training updates; slot 0 lands at the lower position.
module core_bpu_upd_fifo
    import core_bpu_arbiter_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push0,
    input  bpu_correct_t push0_data,
    input  logic         push1,
    input  bpu_correct_t push1_data,
    input  logic         pop,
    output bpu_correct_t head,
    output logic         head_valid,
    output logic [AW:0]  count
);

    bpu_correct_t mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [1:0]    n_push_s;
    logic          do_pop_s;
    bpu_correct_t  wr_first_s;

    // Push/pop bookkeeping; a lone slot-1 push takes the first free position.
    always_comb begin
        n_push_s   = {1'b0, push0} + {1'b0, push1};
        do_pop_s   = pop & (count_r != {(AW+1){1'b0}});
        wr_first_s = push0 ? push0_data : push1_data;
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push0 | push1) begin
                mem_r[wr_ptr_r] <= wr_first_s;
            end
            if (push0 & push1) begin
                mem_r[wr_ptr_r + AW'(1)] <= push1_data;
            end
            wr_ptr_r <= wr_ptr_r + AW'(n_push_s);
            rd_ptr_r <= rd_ptr_r + AW'(do_pop_s);
            count_r  <= count_r + (AW+1)'(n_push_s) - (AW+1)'(do_pop_s);
        end
    end

    assign head       = mem_r[rd_ptr_r];
    assign head_valid = (count_r != {(AW+1){1'b0}});
    assign count      = count_r;

endmodule

// File: rtl/core_bpu_arbiter.sv
// Picks the redirecting jump-unit result, squashes wrong-path results after a
// redirect, and queues BPU training updates.
module core_bpu_arbiter
    import core_bpu_arbiter_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int SQUASH_CYC = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           valid_i,
    input  bpu_correct_t [1:0]   correct_i,
    output logic                 redirect_o,
    output logic [31:0]          redirect_pc_o,
    output logic [RAS_PTR_W-1:0] redirect_ras_ptr_o,
    output logic                 upd_valid_o,
    input  logic                 upd_ready_i,
    output bpu_correct_t         upd_o,
    output logic                 stall_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SQ_W  = (SQUASH_CYC > 1) ? $clog2(SQUASH_CYC) : 1;

    arb_state_e      state_r;
    arb_state_e      state_next_s;
    logic [SQ_W-1:0] sq_cnt_r;
    logic [SQ_W-1:0] sq_cnt_next_s;
    logic            s0_s;
    logic            s1_s;
    logic            win0_s;
    logic            win1_s;
    logic            redirect_s;
    logic            push0_s;
    logic            push1_s;
    logic [CNT_W-1:0] count_s;

    // Slot qualification: a slot-0 miss kills the younger slot 1.
    always_comb begin
        s0_s       = (state_r == ARB_IDLE) & valid_i[0];
        s1_s       = (state_r == ARB_IDLE) & valid_i[1] & ~(s0_s & correct_i[0].miss);
        win0_s     = s0_s & correct_i[0].miss;
        win1_s     = ~win0_s & s1_s & correct_i[1].miss;
        redirect_s = win0_s | win1_s;
        push0_s    = s0_s & entry_wanted(correct_i[0]);
        push1_s    = s1_s & entry_wanted(correct_i[1]);
    end

    // Squash FSM next state: the counter is loaded on entry and IDLE resumes after it reads zero.
    always_comb begin
        state_next_s  = state_r;
        sq_cnt_next_s = sq_cnt_r;
        case (state_r)
            ARB_IDLE: begin
                if (redirect_s) begin
                    state_next_s  = ARB_SQUASH;
                    sq_cnt_next_s = SQ_W'(SQUASH_CYC - 1);
                end else begin
                    state_next_s  = ARB_IDLE;
                end
            end
            ARB_SQUASH: begin
                if (sq_cnt_r == {SQ_W{1'b0}}) begin
                    state_next_s = ARB_IDLE;
                end else begin
                    sq_cnt_next_s = sq_cnt_r - SQ_W'(1);
                end
            end
            default: begin
                state_next_s  = ARB_IDLE;
                sq_cnt_next_s = {SQ_W{1'b0}};
            end
        endcase
    end

    // Squash FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ARB_IDLE;
            sq_cnt_r <= {SQ_W{1'b0}};
        end else begin
            state_r  <= state_next_s;
            sq_cnt_r <= sq_cnt_next_s;
        end
    end

    // Redirect pulse and target; target and RAS pointer hold until the next redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_o         <= 1'b0;
            redirect_pc_o      <= 32'h0000_0000;
            redirect_ras_ptr_o <= {RAS_PTR_W{1'b0}};
        end else begin
            redirect_o <= redirect_s;
            if (redirect_s) begin
                redirect_pc_o      <= win0_s ? correct_i[0].true_target : correct_i[1].true_target;
                redirect_ras_ptr_o <= win0_s ? correct_i[0].ras_ptr : correct_i[1].ras_ptr;
            end
        end
    end

    core_bpu_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push0      (push0_s),
        .push0_data (correct_i[0]),
        .push1      (push1_s),
        .push1_data (correct_i[1]),
        .pop        (upd_valid_o & upd_ready_i),
        .head       (upd_o),
        .head_valid (upd_valid_o),
        .count      (count_s)
    );

    assign stall_o = (count_s > CNT_W'(DEPTH - 2));

endmodule
